dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel arbiter and bus-request sequencer for the 4-channel DMA controller. It qualifies the per-channel DREQ lines with mask, software-request and polarity settings. It runs the HRQ/HLDA hold handshake with the host CPU, picks one channel by fixed or rotating priority, and drives DACK for that channel until the timing-and-control block signals end of service. It sits between the bus interface (DREQ, HLDA, HRQ, DACK) and the timing-and-control and datapath blocks, which consume grantChannel and grantValid.

## Interface
- CHANNELS, 4: number of DMA channels; all per-channel vectors are this wide.
- CHW, $clog2(CHANNELS): width of the channel index.

- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  reset, asynchronous and active-high.
- DREQ  input  CHANNELS  raw DMA request lines.
- HLDA  input  1  hold acknowledge from the CPU.
- mask  input  CHANNELS  1 = channel masked; masked channels cannot win.
- softReq  input  CHANNELS  software request bits; these are never masked.
- rotatingPriority  input  1  0 = fixed priority (ch0 highest); 1 = rotating priority.
- dreqSense  input  1  0 = DREQ active-high; 1 = DREQ active-low.
- dackSense  input  1  0 = DACK active-low; 1 = DACK active-high.
- serviceEnd  input  1  one-cycle pulse from timing-and-control at terminal count or EOP.
- HRQ  output  1  hold request to the CPU.
- DACK  output  CHANNELS  DMA acknowledge lines; at most one is asserted.
- grantValid  output  1  1 while a channel is being serviced.
- grantChannel  output  CHW  index of the serviced channel; holds its last value when idle.
- serviceDone  output  1  one-cycle pulse when a service ends normally.
- serviceAbort  output  1  one-cycle pulse when HLDA is lost during service.

## Operation
- Effective request per channel: reqEff[i] = ((DREQ[i] XOR dreqSense) AND NOT mask[i]) OR softReq[i].
- Configuration latching:
  - rotatingPriority, dreqSense and dackSense are latched only in IDLE.
  - Changes made while not in IDLE take effect on the next return to IDLE.
  - mask and softReq are live in every state.
- Priority:
  - Fixed mode: the lowest-numbered requesting channel wins.
  - Rotating mode: a pointer prio holds the highest-priority channel. Search order is prio, prio+1, … modulo CHANNELS.
  - After any completed or aborted service on channel c, prio becomes (c+1) mod CHANNELS.
  - In fixed mode prio is held at 0.
- States:
  - IDLE: HRQ=0, DACK inactive. If any reqEff, go to REQ.
  - REQ: HRQ=1.
    - If no reqEff remains, go to IDLE (HRQ drops).
    - Else if HLDA=1, arbitrate over the current reqEff, latch the winner, and go to SERVE.
  - SERVE: HRQ=1, DACK[winner] asserted, grantValid=1.
    - HLDA=0: go to IDLE, pulse serviceAbort.
    - Else if serviceEnd=1, or reqEff[winner]=0: go to RELEASE, pulse serviceDone.
  - RELEASE: HRQ=0, DACK inactive, grantValid=0. When HLDA=0, go to IDLE.
- The winner is not re-arbitrated during SERVE. Higher-priority requests that arrive mid-service wait for the next cycle through the states.
- Inactive DACK level is NOT dackSense. The DACK polarity flips only in IDLE, together with the dackSense latch.

## Timing
- All outputs are registered. Inputs are sampled at the rising CLK edge and outputs change after that same edge.
- DREQ valid before edge k (in IDLE): HRQ=1 after edge k.
- HLDA=1 sampled at edge m (in REQ): DACK, grantValid and grantChannel valid after edge m. Minimum DREQ-to-DACK latency is 2 edges.
- Service end:
  - serviceEnd or request drop sampled at edge p: DACK inactive, HRQ=0, grantValid=0 after edge p.
  - serviceDone is high for exactly the cycle after edge p.
- Ending events in SERVE: HLDA loss has precedence over serviceEnd when both occur at the same edge. Only serviceAbort pulses.
- Re-request: the earliest new HRQ comes one edge after HLDA=0 is sampled in RELEASE.
- Reset values, applied immediately on RESET high regardless of CLK:
  - state = IDLE, HRQ = 0, DACK = all 1s (active-low default), grantValid = 0.
  - grantChannel = 0, serviceDone = 0, serviceAbort = 0, prio = 0.
  - Latched config = 0.
- Reset mid-service drops HRQ and DACK immediately. No serviceDone or serviceAbort pulse is issued.

## Test plan
- Single request: DREQ=4'b0100 and dreqSense=0 at edge 1, HLDA=1 at edge 3.
  - HRQ=1 after edge 1.
  - DACK=4'b1011 and grantChannel=2 after edge 3.
  - serviceEnd at edge 6 → DACK=4'b1111, HRQ=0, serviceDone pulse.
- Fixed priority: DREQ=4'b1010 with HLDA granted → ch1 wins. After release, with DREQ still 4'b1010, ch1 wins again.
- Rotating priority: rotatingPriority=1 and DREQ=4'b1111 over four back-to-back services → grant order 0,1,2,3.
- Mask and softReq: mask=4'b1111 with DREQ=4'b1111 gives HRQ=0 indefinitely. Adding softReq=4'b1000 gives HRQ=1 and then DACK[3].
- HLDA loss: HLDA drops during SERVE on ch0, in the same cycle as serviceEnd → serviceAbort pulses, no serviceDone, state returns to IDLE, and prio=1 in rotating mode.
- Async reset: RESET asserted between edges during SERVE → HRQ=0 and DACK=4'b1111 before the next edge. Configuration changes made during SERVE are not applied until IDLE.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// Bus bundle between the DMA channel arbiter and its neighbours.
// slave  : arbiter side (DMA request/config/service inputs, hold/ack/grant outputs)
// master : environment side (bus interface, timing-and-control, CPU, testbench)
interface dma_priority_arbiter_if #(
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] DREQ;
  logic                HLDA;
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] softReq;
  logic                rotatingPriority;
  logic                dreqSense;
  logic                dackSense;
  logic                serviceEnd;

  logic                HRQ;
  logic [CHANNELS-1:0] DACK;
  logic                grantValid;
  logic [CHW-1:0]      grantChannel;
  logic                serviceDone;
  logic                serviceAbort;

  modport slave (
    input  DREQ, HLDA, mask, softReq, rotatingPriority, dreqSense, dackSense, serviceEnd,
    output HRQ, DACK, grantValid, grantChannel, serviceDone, serviceAbort
  );

  modport master (
    output DREQ, HLDA, mask, softReq, rotatingPriority, dreqSense, dackSense, serviceEnd,
    input  HRQ, DACK, grantValid, grantChannel, serviceDone, serviceAbort
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter and HRQ/HLDA bus-request sequencer.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - asynchronous, active-high reset
//   bus   - dma_priority_arbiter_if.slave: DREQ/mask/softReq/config/serviceEnd/HLDA in,
//           HRQ/DACK/grantValid/grantChannel/serviceDone/serviceAbort out (all registered)
module dma_priority_arbiter #(
  parameter int unsigned CHANNELS = 4
) (
  input logic                   CLK,
  input logic                   RESET,
  dma_priority_arbiter_if.slave bus
);
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVE, RELEASE} state_t;

  state_t              state, state_nx;
  logic                cfg_rot, cfg_dsense, cfg_dack;
  logic                rot_eff, dsense_eff, dack_eff;
  logic [CHANNELS-1:0] req_eff;
  logic                any_req;
  logic [CHW-1:0]      prio, prio_nx;
  logic [CHW-1:0]      start, idx, winner;
  logic                found;

  logic                hrq_q, gv_q, done_q, abort_q;
  logic [CHANNELS-1:0] dack_q;
  logic [CHW-1:0]      gch_q;
  logic                hrq_nx, gv_nx, done_nx, abort_nx;
  logic [CHANNELS-1:0] dack_nx;
  logic [CHW-1:0]      gch_nx;

  // Config is transparent in IDLE (same edge that latches it) and frozen elsewhere
  assign rot_eff    = (state == IDLE) ? bus.rotatingPriority : cfg_rot;
  assign dsense_eff = (state == IDLE) ? bus.dreqSense        : cfg_dsense;
  assign dack_eff   = (state == IDLE) ? bus.dackSense        : cfg_dack;

  // Qualified requests; software requests bypass mask and polarity
  assign req_eff = ((bus.DREQ ^ {CHANNELS{dsense_eff}}) & ~bus.mask) | bus.softReq;
  assign any_req = |req_eff;

  // Circular search starting at the highest-priority channel
  always_comb begin
    start  = rot_eff ? prio : '0;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = CHW'((32'(start) + i) % CHANNELS);
      if (!found && req_eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cfg_rot    <= 1'b0;
      cfg_dsense <= 1'b0;
      cfg_dack   <= 1'b0;
      prio       <= '0;
      hrq_q      <= 1'b0;
      dack_q     <= '1;
      gv_q       <= 1'b0;
      gch_q      <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        cfg_rot    <= bus.rotatingPriority;
        cfg_dsense <= bus.dreqSense;
        cfg_dack   <= bus.dackSense;
      end
      prio    <= prio_nx;
      hrq_q   <= hrq_nx;
      dack_q  <= dack_nx;
      gv_q    <= gv_nx;
      gch_q   <= gch_nx;
      done_q  <= done_nx;
      abort_q <= abort_nx;
    end
  end

  // Next-state logic; HLDA loss outranks serviceEnd in SERVE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = REQ;
      REQ: begin
        if (!any_req)      state_nx = IDLE;
        else if (bus.HLDA) state_nx = SERVE;
      end
      SERVE: begin
        if (!bus.HLDA)                                state_nx = IDLE;
        else if (bus.serviceEnd || !req_eff[gch_q])   state_nx = RELEASE;
      end
      RELEASE: if (!bus.HLDA) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and the priority pointer
  always_comb begin
    hrq_nx   = 1'b0;
    gv_nx    = 1'b0;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    gch_nx   = gch_q;
    prio_nx  = rot_eff ? prio : '0;
    dack_nx  = {CHANNELS{~dack_eff}};

    if (state == REQ && state_nx == SERVE) gch_nx = winner;

    if (state_nx == REQ) hrq_nx = 1'b1;
    if (state_nx == SERVE) begin
      hrq_nx          = 1'b1;
      gv_nx           = 1'b1;
      dack_nx[gch_nx] = dack_eff;
    end

    // Leaving SERVE by any route advances the rotating pointer past the served channel
    if (state == SERVE && state_nx != SERVE) begin
      done_nx  = (state_nx == RELEASE);
      abort_nx = (state_nx == IDLE);
      prio_nx  = rot_eff ? CHW'((32'(gch_q) + 32'd1) % CHANNELS) : '0;
    end
  end

  assign bus.HRQ          = hrq_q;
  assign bus.DACK         = dack_q;
  assign bus.grantValid   = gv_q;
  assign bus.grantChannel = gch_q;
  assign bus.serviceDone  = done_q;
  assign bus.serviceAbort = abort_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios then a randomized
// run, each cycle compared against a behavioural model of the channel arbiter.
module tb_dma_priority_arbiter;
  logic CLK;
  logic RESET;

  dma_priority_arbiter_if #(.CHANNELS(4)) bus ();

  dma_priority_arbiter #(.CHANNELS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phases of the hold handshake
  localparam int P_IDLE = 0, P_REQ = 1, P_SERVE = 2, P_REL = 3;
  int         m_phase, m_prio, m_ch;
  bit         m_rot, m_ds, m_dk;
  logic       exp_hrq, exp_gv, exp_done, exp_abort;
  logic [3:0] exp_dack;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_prio = 0; m_ch = 0;
    m_rot = 0; m_ds = 0; m_dk = 0;
    exp_hrq = 0; exp_gv = 0; exp_done = 0; exp_abort = 0; exp_dack = 4'hF;
  endtask

  task automatic model_edge();
    bit [3:0] r;
    int nxt, c;
    bit found;
    if (m_phase == P_IDLE) begin
      m_rot = bus.rotatingPriority; m_ds = bus.dreqSense; m_dk = bus.dackSense;
    end
    for (int i = 0; i < 4; i++)
      r[i] = ((bus.DREQ[i] ^ m_ds) & ~bus.mask[i]) | bus.softReq[i];
    if (!m_rot) m_prio = 0;
    nxt = m_phase; exp_done = 0; exp_abort = 0;
    case (m_phase)
      P_IDLE: if (r != 0) nxt = P_REQ;
      P_REQ: begin
        if (r == 0) nxt = P_IDLE;
        else if (bus.HLDA) begin
          found = 0;
          for (int k = 0; k < 4; k++) begin
            c = (m_prio + k) % 4;
            if (!found && r[c]) begin m_ch = c; found = 1; end
          end
          nxt = P_SERVE;
        end
      end
      P_SERVE: begin
        if (!bus.HLDA) begin
          nxt = P_IDLE; exp_abort = 1; m_prio = m_rot ? (m_ch + 1) % 4 : 0;
        end else if (bus.serviceEnd || !r[m_ch]) begin
          nxt = P_REL; exp_done = 1; m_prio = m_rot ? (m_ch + 1) % 4 : 0;
        end
      end
      default: if (!bus.HLDA) nxt = P_IDLE;
    endcase
    m_phase  = nxt;
    exp_hrq  = (nxt == P_REQ) || (nxt == P_SERVE);
    exp_gv   = (nxt == P_SERVE);
    exp_dack = m_dk ? 4'h0 : 4'hF;
    if (nxt == P_SERVE) exp_dack[m_ch] = m_dk;
  endtask

  task automatic check_model(input string tag);
    logic [1:0] ech;
    ech = 2'(m_ch);
    chk({tag, ".hrq"},   {3'b0, bus.HRQ},          {3'b0, exp_hrq});
    chk({tag, ".dack"},  bus.DACK,                 exp_dack);
    chk({tag, ".gv"},    {3'b0, bus.grantValid},   {3'b0, exp_gv});
    chk({tag, ".gch"},   {2'b0, bus.grantChannel}, {2'b0, ech});
    chk({tag, ".done"},  {3'b0, bus.serviceDone},  {3'b0, exp_done});
    chk({tag, ".abort"}, {3'b0, bus.serviceAbort}, {3'b0, exp_abort});
  endtask

  // One rising edge: advance the model with the inputs seen at the edge, then compare
  task automatic cyc(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // From IDLE: wait for HRQ, grant hold, end service, release hold
  task automatic run_service(input string tag, input int exp_c);
    int n = 0;
    cyc(tag);
    while (!bus.HRQ && n < 20) begin cyc(tag); n++; end
    chk({tag, ".hrq_wait"}, {3'b0, bus.HRQ}, 4'd1);
    bus.HLDA = 1'b1;
    cyc(tag);
    chk({tag, ".winner"}, {2'b0, bus.grantChannel}, 4'(exp_c));
    bus.serviceEnd = 1'b1;
    cyc(tag);
    bus.serviceEnd = 1'b0;
    chk({tag, ".done_pulse"}, {3'b0, bus.serviceDone}, 4'd1);
    bus.HLDA = 1'b0;
    cyc(tag);
  endtask

  initial begin
    RESET = 1'b1;
    bus.DREQ = '0; bus.HLDA = 0; bus.mask = '0; bus.softReq = '0;
    bus.rotatingPriority = 0; bus.dreqSense = 0; bus.dackSense = 0; bus.serviceEnd = 0;
    model_reset();
    #3;
    chk("reset.hrq",  {3'b0, bus.HRQ},          4'd0);
    chk("reset.dack", bus.DACK,                 4'hF);
    chk("reset.gv",   {3'b0, bus.grantValid},   4'd0);
    chk("reset.gch",  {2'b0, bus.grantChannel}, 4'd0);
    chk("reset.done", {3'b0, bus.serviceDone},  4'd0);
    chk("reset.abrt", {3'b0, bus.serviceAbort}, 4'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single request on ch2
    bus.DREQ = 4'b0100;
    cyc("single.e1");
    chk("single.hrq_e1", {3'b0, bus.HRQ}, 4'd1);
    cyc("single.e2");
    bus.HLDA = 1'b1;
    cyc("single.e3");
    chk("single.dack_e3", bus.DACK, 4'b1011);
    chk("single.gch_e3",  {2'b0, bus.grantChannel}, 4'd2);
    cyc("single.e4");
    cyc("single.e5");
    bus.serviceEnd = 1'b1;
    cyc("single.e6");
    bus.serviceEnd = 1'b0;
    chk("single.dack_e6", bus.DACK, 4'hF);
    chk("single.hrq_e6",  {3'b0, bus.HRQ}, 4'd0);
    chk("single.done_e6", {3'b0, bus.serviceDone}, 4'd1);
    bus.DREQ = '0;
    cyc("single.e7");
    chk("single.done_e7", {3'b0, bus.serviceDone}, 4'd0);
    bus.HLDA = 1'b0;
    cyc("single.e8");

    // Fixed priority: ch1 wins twice
    bus.DREQ = 4'b1010;
    run_service("fixed1", 1);
    run_service("fixed2", 1);

    // Rotating priority round robin
    bus.rotatingPriority = 1'b1;
    bus.DREQ = 4'b1111;
    run_service("rot0", 0);
    run_service("rot1", 1);
    run_service("rot2", 2);
    run_service("rot3", 3);
    bus.rotatingPriority = 1'b0;
    bus.DREQ = '0;
    cyc("rot.idle");

    // Mask blocks everything; softReq bypasses it
    bus.mask = 4'b1111;
    bus.DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc("masked");
      chk("masked.hrq", {3'b0, bus.HRQ}, 4'd0);
    end
    bus.softReq = 4'b1000;
    run_service("softreq", 3);
    chk("softreq.dack_idle", bus.DACK, 4'hF);
    bus.softReq = '0;
    bus.mask = '0;
    bus.DREQ = '0;
    cyc("soft.idle");

    // HLDA loss together with serviceEnd on ch0, rotating mode
    bus.rotatingPriority = 1'b1;
    bus.DREQ = 4'b0001;
    cyc("abort.req");
    bus.HLDA = 1'b1;
    cyc("abort.serve");
    chk("abort.gch", {2'b0, bus.grantChannel}, 4'd0);
    bus.HLDA = 1'b0;
    bus.serviceEnd = 1'b1;
    cyc("abort.edge");
    bus.serviceEnd = 1'b0;
    chk("abort.pulse", {3'b0, bus.serviceAbort}, 4'd1);
    chk("abort.nodone", {3'b0, bus.serviceDone}, 4'd0);
    chk("abort.hrq", {3'b0, bus.HRQ}, 4'd0);
    bus.DREQ = 4'b1111;
    run_service("abort.prio1", 1);
    bus.rotatingPriority = 1'b0;
    bus.DREQ = '0;
    cyc("abort.idle");

    // Config change during SERVE applies only after the return to IDLE
    bus.DREQ = 4'b0100;
    cyc("cfg.req");
    bus.HLDA = 1'b1;
    cyc("cfg.serve");
    bus.dackSense = 1'b1;
    cyc("cfg.held");
    chk("cfg.dack_held", bus.DACK, 4'b1011);
    bus.serviceEnd = 1'b1;
    cyc("cfg.release");
    bus.serviceEnd = 1'b0;
    chk("cfg.dack_rel", bus.DACK, 4'hF);
    bus.HLDA = 1'b0;
    cyc("cfg.idle");
    cyc("cfg.req2");
    chk("cfg.dack_newpol", bus.DACK, 4'h0);
    bus.HLDA = 1'b1;
    cyc("cfg.serve2");
    chk("cfg.dack_hi", bus.DACK, 4'b0100);

    // Asynchronous reset between edges during SERVE
    bus.dackSense = 1'b0;
    RESET = 1'b1;
    #1;
    chk("areset.hrq",  {3'b0, bus.HRQ}, 4'd0);
    chk("areset.dack", bus.DACK, 4'hF);
    chk("areset.gv",   {3'b0, bus.grantValid}, 4'd0);
    chk("areset.done", {3'b0, bus.serviceDone}, 4'd0);
    model_reset();
    #1;
    RESET = 1'b0;
    bus.HLDA = 1'b0;
    bus.DREQ = '0;
    cyc("areset.after");

    // Randomized run with a cooperative CPU that occasionally revokes the bus
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.DREQ = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) bus.softReq = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        bus.rotatingPriority = 1'($urandom_range(0, 1));
        bus.dreqSense        = 1'($urandom_range(0, 1));
        bus.dackSense        = 1'($urandom_range(0, 1));
      end
      if (exp_hrq && !bus.HLDA && $urandom_range(0, 2) != 0) bus.HLDA = 1'b1;
      else if (!exp_hrq && bus.HLDA && $urandom_range(0, 2) != 0) bus.HLDA = 1'b0;
      else if (bus.HLDA && $urandom_range(0, 30) == 0) bus.HLDA = 1'b0;
      bus.serviceEnd = ($urandom_range(0, 5) == 0);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
